// File: rtl/dcache_memresp_pkg.sv
// Shared definitions for the dcache memory responder: FSM state encoding,
// a ceil-log2 helper for the burst index width, and the read pipeline depth.
// Build option: DCACHE_MEMRESP_RAMREG_EN adds a register stage on ram_rdata,
// which raises the read latency from 2 to 3.
package dcache_memresp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    // Smallest n with 2**n >= value; used to size the in-line beat index.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Registered stages from ram_re to mem_out_valid.
`ifdef DCACHE_MEMRESP_RAMREG_EN
    localparam int RD_LAT = 3;
`else
    localparam int RD_LAT = 2;
`endif

endpackage

// File: rtl/dcache_memresp_addrgen.sv
// Burst address generator: latches the word index at request acceptance, steps
// a beat counter, and forms the critical-word-first address that wraps inside
// the aligned line. Flags the last beat and holds a done flag afterwards.
module dcache_memresp_addrgen
    import dcache_memresp_pkg::*;
#(
    parameter int BURSTLEN    = 8,
    parameter int RAMADDRBITS = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [RAMADDRBITS-1:0] widx,
    input  logic                   advance,
    output logic [RAMADDRBITS-1:0] ram_addr,
    output logic                   last,
    output logic                   done
);

    localparam int L = clog2(BURSTLEN);

    logic [RAMADDRBITS-1:0] widx_reg;
    logic [L-1:0]           beat_reg;
    logic                   done_reg;
    logic [L-1:0]           low_sum;

    // Latch the start index on acceptance, then step one beat per advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            widx_reg <= '0;
            beat_reg <= '0;
            done_reg <= 1'b0;
        end else if (load) begin
            widx_reg <= widx;
            beat_reg <= '0;
            done_reg <= 1'b0;
        end else if (advance && !done_reg) begin
            beat_reg <= beat_reg + 1'b1;
            if (last) begin
                done_reg <= 1'b1;
            end
        end
    end

    // The L-bit sum drops its carry, so the burst wraps inside the line.
    assign low_sum = widx_reg[L-1:0] + beat_reg;

    // Low L address bits come from the wrapped sum; upper bits stay fixed.
    genvar gi;
    generate
        for (gi = 0; gi < RAMADDRBITS; gi++) begin : g_addr_bit
            if (gi < L) begin : g_low
                assign ram_addr[gi] = low_sum[gi];
            end else begin : g_high
                assign ram_addr[gi] = widx_reg[gi];
            end
        end
    endgenerate

    assign last = (beat_reg == L'(BURSTLEN - 1));
    assign done = done_reg;

endmodule

// File: rtl/dcache_memresp.sv
// Data-cache memory responder. Serves level read/write burst requests from the
// dcache against a single-port synchronous RAM. Reads return a critical-word-
// first wrapping burst; writes take one word per cycle and ack each one. A
// one-cycle TURN state follows every burst so the requester can drop its level
// request. Build option: DCACHE_MEMRESP_RAMREG_EN (extra ram_rdata register).
module dcache_memresp
    import dcache_memresp_pkg::*;
#(
    parameter int DATABITS    = 32,
    parameter int ADDRBITS    = 32,
    parameter int BURSTLEN    = 8,
    parameter int RAMADDRBITS = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDRBITS-1:0]    mem_addr,
    input  logic [DATABITS-1:0]    mem_in,
    output logic [DATABITS-1:0]    mem_out,
    output logic                   mem_out_valid,
    input  logic                   mem_rdreq,
    input  logic                   mem_wrreq,
    output logic [15:0]            mem_burstlen,
    output logic [RAMADDRBITS-1:0] ram_addr,
    output logic [DATABITS-1:0]    ram_wdata,
    output logic                   ram_we,
    output logic                   ram_re,
    input  logic [DATABITS-1:0]    ram_rdata
);

    state_t                 state_reg;
    state_t                 state_next;
    logic                   accept;
    logic                   rd_issue;
    logic                   wr_beat;
    logic                   ag_advance;
    logic                   ag_last;
    logic                   ag_done;
    logic [RAMADDRBITS-1:0] req_widx;
    logic [RAMADDRBITS-1:0] ag_addr;
    logic [RD_LAT-1:0]      rd_pipe_reg;
    logic [DATABITS-1:0]    rd_src;
    logic [DATABITS-1:0]    mem_out_reg;
    logic                   unused_addr_bits;

    // Word index of the request; byte offset and bits above the RAM are dropped.
    assign req_widx = mem_addr[RAMADDRBITS+1:2];

    generate
        if (ADDRBITS > RAMADDRBITS + 2) begin : g_addr_upper
            assign unused_addr_bits = ^{mem_addr[ADDRBITS-1:RAMADDRBITS+2], mem_addr[1:0]};
        end else begin : g_addr_noupper
            assign unused_addr_bits = ^mem_addr[1:0];
        end
    endgenerate

    assign accept     = (state_reg == ST_IDLE) && (mem_wrreq || mem_rdreq);
    assign rd_issue   = (state_reg == ST_RD) && !ag_done;
    assign wr_beat    = (state_reg == ST_WR);
    assign ag_advance = rd_issue || wr_beat;

    dcache_memresp_addrgen #(
        .BURSTLEN    (BURSTLEN),
        .RAMADDRBITS (RAMADDRBITS)
    ) u_addrgen (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .widx     (req_widx),
        .advance  (ag_advance),
        .ram_addr (ag_addr),
        .last     (ag_last),
        .done     (ag_done)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: write wins in IDLE so a dirty eviction precedes the refill;
    // a read leaves RD only once every issued beat has reached mem_out.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem_wrreq) begin
                    state_next = ST_WR;
                end else if (mem_rdreq) begin
                    state_next = ST_RD;
                end
            end
            ST_RD: begin
                if (ag_done && (rd_pipe_reg[RD_LAT-2:0] == '0)) begin
                    state_next = ST_TURN;
                end
            end
            ST_WR: begin
                if (ag_last) begin
                    state_next = ST_TURN;
                end
            end
            ST_TURN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Read-valid delay line: bit 0 marks ram_rdata holding a beat, the top
    // bit marks mem_out holding it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pipe_reg <= '0;
        end else begin
            rd_pipe_reg <= {rd_pipe_reg[RD_LAT-2:0], rd_issue};
        end
    end

`ifdef DCACHE_MEMRESP_RAMREG_EN
    logic [DATABITS-1:0] rdata_q_reg;

    // Extra retiming register between the RAM output and mem_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q_reg <= '0;
        end else begin
            rdata_q_reg <= ram_rdata;
        end
    end

    assign rd_src = rdata_q_reg;
`else
    assign rd_src = ram_rdata;
`endif

    // mem_out register: carries read data only on valid beats, zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_out_reg <= '0;
        end else if (rd_pipe_reg[RD_LAT-2]) begin
            mem_out_reg <= rd_src;
        end else begin
            mem_out_reg <= '0;
        end
    end

    assign mem_out       = mem_out_reg;
    assign mem_out_valid = wr_beat || rd_pipe_reg[RD_LAT-1];
    assign ram_re        = rd_issue;
    assign ram_we        = wr_beat;
    assign ram_addr      = ag_advance ? ag_addr : '0;
    assign ram_wdata     = wr_beat ? mem_in : '0;
    assign mem_burstlen  = 16'(BURSTLEN);

endmodule

// File: tb/tb_dcache_memresp.sv
// Testbench for dcache_memresp: a behavioural RAM, a reference memory image,
// directed scenarios from the test plan and a randomized read/write mix.
module tb_dcache_memresp;

    localparam int BL  = 8;
    localparam int RAB = 12;
`ifdef DCACHE_MEMRESP_RAMREG_EN
    localparam int RD_LAT = 3;
`else
    localparam int RD_LAT = 2;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_in;
    logic [31:0]     mem_out;
    logic            mem_out_valid;
    logic            mem_rdreq;
    logic            mem_wrreq;
    logic [15:0]     mem_burstlen;
    logic [RAB-1:0]  ram_addr;
    logic [31:0]     ram_wdata;
    logic            ram_we;
    logic            ram_re;
    logic [31:0]     ram_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram_array [1 << RAB];
    logic [31:0] ref_mem   [1 << RAB];
    logic        ram_init_done = 1'b0;

    always #5 clk = ~clk;

    dcache_memresp dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_in        (mem_in),
        .mem_out       (mem_out),
        .mem_out_valid (mem_out_valid),
        .mem_rdreq     (mem_rdreq),
        .mem_wrreq     (mem_wrreq),
        .mem_burstlen  (mem_burstlen),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_we        (ram_we),
        .ram_re        (ram_re),
        .ram_rdata     (ram_rdata)
    );

    // Power-up contents: 0x40..0x47 hold 0x100..0x107, the rest a hash.
    function automatic logic [31:0] init_val(input int i);
        if (i >= 'h40 && i <= 'h47) return 32'h100 + 32'(i - 'h40);
        return 32'(i * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    // Address of beat i: same aligned line, offset advanced mod BL.
    function automatic logic [RAB-1:0] beat_addr(input logic [RAB-1:0] widx, input int i);
        int w;
        w = int'(widx);
        return RAB'((w - (w % BL)) + ((w % BL + i) % BL));
    endfunction

    // Synchronous single-port RAM model.
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < (1 << RAB); i++) ram_array[i] <= init_val(i);
            ram_init_done <= 1'b1;
        end else begin
            if (ram_we) ram_array[ram_addr] <= ram_wdata;
            if (ram_re) ram_rdata <= ram_array[ram_addr];
        end
    end

    task automatic check_turn(input string tag);
        total++;
        if (ram_re !== 1'b0 || ram_we !== 1'b0 || mem_out_valid !== 1'b0 || mem_out !== 32'h0) begin
            bad++;
            $display("FAIL turn[%s]: re=%b we=%b valid=%b out=%h, want all 0", tag, ram_re, ram_we, mem_out_valid, mem_out);
        end
    endtask

    // Read burst: checks acceptance, first-valid latency, contiguity and data.
    task automatic run_read(input logic [31:0] addr, input string tag);
        logic [RAB-1:0] widx;
        logic [RAB-1:0] ea;
        int first_n, nvalid, gaps;
        widx = addr[RAB+1:2];
        @(negedge clk);
        mem_addr  = addr;
        mem_rdreq = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ram_re !== 1'b1 || ram_addr !== widx) begin
            bad++;
            $display("FAIL rd_accept[%s]: re=%b addr=%h, want re=1 addr=%h", tag, ram_re, ram_addr, widx);
        end
        first_n = -1;
        nvalid  = 0;
        gaps    = 0;
        for (int n = 1; n <= BL + RD_LAT + 4; n++) begin
            @(posedge clk);
            #1;
            if (mem_out_valid === 1'b1) begin
                if (first_n < 0) first_n = n;
                if (n != first_n + nvalid) gaps++;
                ea = beat_addr(widx, nvalid);
                total++;
                if (mem_out !== ref_mem[ea]) begin
                    bad++;
                    $display("FAIL rd_data[%s beat %0d]: got %h want %h (word %h)", tag, nvalid, mem_out, ref_mem[ea], ea);
                end
                nvalid++;
                if (nvalid == BL) break;
            end
        end
        mem_rdreq = 1'b0;
        total++;
        if (first_n != RD_LAT) begin
            bad++;
            $display("FAIL rd_latency[%s]: first valid %0d edges after accept, want %0d", tag, first_n, RD_LAT);
        end
        total++;
        if (nvalid != BL || gaps != 0) begin
            bad++;
            $display("FAIL rd_beats[%s]: %0d beats with %0d gaps, want %0d with 0", tag, nvalid, gaps, BL);
        end
        @(posedge clk);
        #1;
        check_turn(tag);
        @(posedge clk);
    endtask

    // Write burst; abort_at < BL asserts reset during that beat.
    task automatic run_write(input logic [31:0] addr, input logic [31:0] wd [BL], input int abort_at, input string tag);
        logic [RAB-1:0] widx;
        logic [RAB-1:0] ea;
        int written;
        widx = addr[RAB+1:2];
        written = BL;
        @(negedge clk);
        mem_addr  = addr;
        mem_wrreq = 1'b1;
        mem_in    = wd[0];
        @(posedge clk);
        for (int b = 0; b < BL; b++) begin
            if (b == abort_at) begin
                #1;
                reset     = 1'b1;
                mem_wrreq = 1'b0;
                #1;
                total++;
                if (ram_we !== 1'b0 || ram_re !== 1'b0 || mem_out_valid !== 1'b0 || ram_addr !== '0) begin
                    bad++;
                    $display("FAIL wr_reset[%s]: we=%b re=%b valid=%b addr=%h, want all 0", tag, ram_we, ram_re, mem_out_valid, ram_addr);
                end
                written = b;
                break;
            end
            #1;
            mem_in = wd[b];
            #1;
            ea = beat_addr(widx, b);
            total++;
            if (ram_we !== 1'b1 || ram_re !== 1'b0 || mem_out_valid !== 1'b1 || mem_out !== 32'h0
                || ram_addr !== ea || ram_wdata !== wd[b]) begin
                bad++;
                $display("FAIL wr_beat[%s %0d]: we=%b re=%b ack=%b out=%h addr=%h wdata=%h, want 1 0 1 0 %h %h",
                         tag, b, ram_we, ram_re, mem_out_valid, mem_out, ram_addr, ram_wdata, ea, wd[b]);
            end
            @(posedge clk);
        end
        for (int b = 0; b < written; b++) ref_mem[beat_addr(widx, b)] = wd[b];
        if (written == BL) begin
            #1;
            mem_wrreq = 1'b0;
            #1;
            check_turn(tag);
            @(posedge clk);
        end else begin
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (mem_out !== 32'h0 || mem_out_valid !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0
            || ram_addr !== '0 || ram_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: out=%h valid=%b we=%b re=%b addr=%h wdata=%h, want all 0",
                     mem_out, mem_out_valid, ram_we, ram_re, ram_addr, ram_wdata);
        end
        total++;
        if (mem_burstlen !== 16'(BL)) begin
            bad++;
            $display("FAIL burstlen: got %0d want %0d", mem_burstlen, BL);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (ram_re !== 1'b0 || ram_we !== 1'b0 || mem_out_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle[%0d]: re=%b we=%b valid=%b, want 0 0 0", i, ram_re, ram_we, mem_out_valid);
            end
        end
    endtask

    task automatic test_aligned_read();
        run_read(32'h0000_0100, "aligned");
    endtask

    task automatic test_wrapped_read();
        run_read(32'h0000_0114, "wrapped");
    endtask

    task automatic test_write_burst();
        logic [31:0] wd [BL];
        for (int i = 0; i < BL; i++) wd[i] = 32'hA0 + 32'(i);
        run_write(32'h0000_0200, wd, BL, "write");
        run_read(32'h0000_0200, "write_readback");
    endtask

    task automatic test_simultaneous();
        logic [31:0] wd [BL];
        for (int i = 0; i < BL; i++) wd[i] = $urandom;
        mem_rdreq = 1'b1;
        run_write(32'h0000_0408, wd, BL, "simul_wr");
        run_read(32'h0000_0400, "simul_rd");
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] wd [BL];
        for (int i = 0; i < BL; i++) wd[i] = 32'hBEEF_0000 + 32'(i);
        run_write(32'h0000_0300, wd, 3, "reset_mid");
        run_read(32'h0000_0300, "reset_mid_readback");
    endtask

    task automatic test_random();
        logic [31:0] wd [BL];
        logic [31:0] addr;
        for (int k = 0; k < 12; k++) begin
            addr = $urandom;
            if (k < 6 || $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < BL; i++) wd[i] = $urandom;
                run_write(addr, wd, BL, $sformatf("rand_wr%0d", k));
                run_read(addr ^ 32'h0000_0004, $sformatf("rand_rb%0d", k));
            end else begin
                run_read(addr, $sformatf("rand_rd%0d", k));
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_rdreq = 1'b0;
        mem_wrreq = 1'b0;
        mem_addr  = 32'h0;
        mem_in    = 32'h0;
        for (int i = 0; i < (1 << RAB); i++) ref_mem[i] = init_val(i);
        repeat (3) @(posedge clk);
        test_reset();
        test_idle();
        test_aligned_read();
        test_wrapped_read();
        test_write_burst();
        test_simultaneous();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
